load_store_unit: RTL and testbench

Multi-cycle data-memory access sequencer for the RV32I core. It sits between the decode/execute stage and the data-memory port.
- Accepts one load or store per handshake, using decoded load/store funct3, the ALU-computed address, store data and the destination register.
- Drives a request/grant/response memory bus with byte enables.
- Sign- or zero-extends load data and returns it for register writeback.
- Stalls the pipeline through req_ready while a transaction is in flight.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/lsu_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store path: opcodes, funct3 encodings,
// sequencer states and error causes.
package riscv_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DONE, ERR} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, load
// extraction/extension and legality checks for one access.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = '0;
        shifted    = rdata >> {offset, 3'b000};

        if (is_store) begin
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end

        // funct3[1:0] encodes access size for both loads and stores
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));

        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase

        case (funct3)
            F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_ext = {24'b0, shifted[7:0]};
            F3_LHU:  rdata_ext = {16'b0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory sequencer: one load/store in flight, registered
// request/grant/response bus outputs, writeback and error pulses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  store_done,
    output logic                  err_valid,
    output logic [1:0]            err_code
);

    localparam int unsigned CntW = $clog2(RESP_TIMEOUT + 2);

    lsu_state_t    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_d;
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;

    logic          idle;
    logic          a_is_store;
    logic [2:0]    a_funct3;
    logic [1:0]    a_offset;
    logic [3:0]    a_be;
    logic [31:0]   a_wdata;
    logic [31:0]   a_rdata;
    logic          a_misaligned;
    logic          a_illegal;
    logic          timed_out;

    // In IDLE the aligner checks the incoming request; afterwards it works on the captured one
    assign idle       = (state_q == IDLE);
    assign a_is_store = idle ? req_is_store : is_store_q;
    assign a_funct3   = idle ? req_funct3 : funct3_q;
    assign a_offset   = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .is_store   (a_is_store),
        .funct3     (a_funct3),
        .offset     (a_offset),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata),
        .misaligned (a_misaligned),
        .illegal    (a_illegal)
    );

    assign timed_out = (RESP_TIMEOUT != 0) && (32'(cnt_q) + 32'd1 >= RESP_TIMEOUT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = ERR_TIMEOUT;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (a_illegal) begin
                        state_d = ERR;
                        err_d   = ERR_ILLEGAL;
                    end else if (a_misaligned) begin
                        state_d = ERR;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = is_store_q ? DONE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                end else if (timed_out) begin
                    state_d = ERR;
                    err_d   = ERR_TIMEOUT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP, DONE, ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            store_done <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= (state_d == IDLE);
            mem_req    <= (state_d == REQ);
            wb_valid   <= (state_d == RESP);
            store_done <= (state_d == DONE);
            err_valid  <= (state_d == ERR);
            if (idle && req_valid) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                off_q      <= req_addr[1:0];
                wb_rd      <= req_rd;
            end
            if (idle && state_d == REQ) begin
                mem_we    <= req_is_store;
                mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_be    <= a_be;
                mem_wdata <= req_is_store ? a_wdata : 32'h0;
            end
            if (state_d == ERR) begin
                err_code <= err_d;
            end
            if (state_q == WAIT && mem_rvalid) begin
                wb_data <= a_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a short response timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_WIDTH   (32),
        .RESP_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .store_done   (store_done),
        .err_valid    (err_valid),
        .err_code     (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one accepting edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Load with grant in the first REQ cycle and rvalid one cycle later
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b0, f3, addr, 32'h0, rd);
        check({tag, " mem_req"}, 32'(mem_req), 32'd1);
        check({tag, " be"}, 32'(mem_be), 32'(exp_be));
        check({tag, " we"}, 32'(mem_we), 32'd0);
        check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        check({tag, " early wb"}, 32'(wb_valid), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, " wb_data"}, wb_data, exp_data);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
        tick();
        check({tag, " wb pulse"}, 32'(wb_valid), 32'd0);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] code);
        issue(st, f3, addr, 32'h0, 5'd0);
        check({tag, " err_valid"}, 32'(err_valid), 32'd1);
        check({tag, " err_code"}, 32'(err_code), 32'(code));
        check({tag, " no mem_req"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, " err pulse"}, 32'(err_valid), 32'd0);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        #12;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst store_done", 32'(store_done), 32'd0);
        check("rst err_valid", 32'(err_valid), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        tick();

        // SW 0x100, grant in first REQ cycle
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        mem_gnt = 1'b1;
        check("sw mem_req", 32'(mem_req), 32'd1);
        check("sw ready low", 32'(req_ready), 32'd0);
        check("sw addr", mem_addr, 32'h100);
        check("sw be", 32'(mem_be), 32'hF);
        check("sw we", 32'(mem_we), 32'd1);
        check("sw wdata", mem_wdata, 32'hDEADBEEF);
        check("sw no early done", 32'(store_done), 32'd0);
        tick();
        mem_gnt = 1'b0;
        check("sw store_done", 32'(store_done), 32'd1);
        check("sw req dropped", 32'(mem_req), 32'd0);
        check("sw ready still low", 32'(req_ready), 32'd0);
        tick();
        check("sw ready", 32'(req_ready), 32'd1);
        check("sw done pulse", 32'(store_done), 32'd0);

        do_load("lb",  3'b000, 32'h203, 5'd5,  32'h80123456, 4'b1000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h203, 5'd6,  32'h80123456, 4'b1000, 32'h00000080);
        do_load("lhu", 3'b101, 32'h202, 5'd7,  32'hBEEF0000, 4'b1100, 32'h0000BEEF);
        do_load("lh",  3'b001, 32'h200, 5'd9,  32'h00008001, 4'b0011, 32'hFFFF8001);
        do_load("lw",  3'b010, 32'h104, 5'd31, 32'h13579BDF, 4'b1111, 32'h13579BDF);

        // SH 0x302 with grant delayed three cycles
        issue(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check("sh mem_req held", 32'(mem_req), 32'd1);
            check("sh addr held", mem_addr, 32'h300);
            check("sh be held", 32'(mem_be), 32'hC);
            check("sh wdata held", mem_wdata, 32'hABCDABCD);
            check("sh we held", 32'(mem_we), 32'd1);
            check("sh no early done", 32'(store_done), 32'd0);
            mem_gnt = (i == 3);
            tick();
        end
        mem_gnt = 1'b0;
        check("sh store_done", 32'(store_done), 32'd1);
        tick();
        check("sh ready", 32'(req_ready), 32'd1);

        // SB lane replication at offset 1
        issue(1'b1, 3'b000, 32'h405, 32'h000000A5, 5'd0);
        check("sb be", 32'(mem_be), 32'h2);
        check("sb wdata", mem_wdata, 32'hA5A5A5A5);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sb store_done", 32'(store_done), 32'd1);
        tick();

        do_err("lw misaligned", 1'b0, 3'b010, 32'h101, 2'b01);
        do_err("lh misaligned", 1'b0, 3'b001, 32'h203, 2'b01);
        do_err("load f3 011",   1'b0, 3'b011, 32'h100, 2'b10);
        do_err("store f3 101 prio", 1'b1, 3'b101, 32'h101, 2'b10);

        // Response timeout after four WAIT cycles
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to no err yet", 32'(err_valid), 32'd0);
            tick();
        end
        check("to err_valid", 32'(err_valid), 32'd1);
        check("to err_code", 32'(err_code), 32'd3);
        check("to no wb", 32'(wb_valid), 32'd0);
        tick();
        check("to ready", 32'(req_ready), 32'd1);

        // Reset during WAIT, then a stale rvalid
        issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rw ready low in wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rw async ready", 32'(req_ready), 32'd1);
        check("rw async mem_req", 32'(mem_req), 32'd0);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        check("rw stale no wb", 32'(wb_valid), 32'd0);
        tick();
        check("rw stale no wb 2", 32'(wb_valid), 32'd0);
        check("rw ready", 32'(req_ready), 32'd1);
        check("rw wb_data clear", wb_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
